// File: rtl/chess_clock_core.sv
// Dual countdown chess clock: per-player min:sec, turn switching with increment,
// pause/resume and sticky timeout flags. All outputs come straight from flops.
module chess_clock_core #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned START_MIN = 5,
    parameter int unsigned START_SEG = 0,
    parameter int unsigned INC_SEG   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       btn1,
    input  logic       btn2,
    output logic [4:0] min1,
    output logic [4:0] min2,
    output logic [5:0] seg1,
    output logic [5:0] seg2,
    output logic       turn,
    output logic [2:0] state,
    output logic       flag1,
    output logic       flag2,
    output logic       tick
);

    localparam int unsigned   CntW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);
    localparam logic [4:0]    MinInit = 5'(START_MIN);
    localparam logic [5:0]    SegInit = 6'(START_SEG);
    localparam logic [6:0]    Inc     = 7'(INC_SEG);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun1   = 3'd1,
        StRun2   = 3'd2,
        StPaused = 3'd3,
        StFlag   = 3'd4
    } state_e;

    state_e          st_q;
    logic [CntW-1:0] cnt_q;

    logic [4:0] act_min;
    logic [5:0] act_seg;
    logic       act_btn;
    logic       act_nonzero;
    logic       at_tc;
    logic [4:0] dec_min;
    logic [5:0] dec_seg;
    logic       dec_zero;
    logic [6:0] inc_sum;
    logic [5:0] inc_min6;
    logic [4:0] inc_min;
    logic [5:0] inc_seg;

    assign state = st_q;

    // Next-time candidates for the active player: one-second decrement and increment.
    always_comb begin
        act_min     = turn ? min2 : min1;
        act_seg     = turn ? seg2 : seg1;
        act_btn     = turn ? btn2 : btn1;
        act_nonzero = (act_min != 5'd0) || (act_seg != 6'd0);
        at_tc       = (cnt_q == CntMax);

        dec_min = act_min;
        dec_seg = act_seg;
        if (act_seg != 6'd0) begin
            dec_seg = act_seg - 6'd1;
        end else if (act_min != 5'd0) begin
            dec_min = act_min - 5'd1;
            dec_seg = 6'd59;
        end
        dec_zero = (dec_min == 5'd0) && (dec_seg == 6'd0);

        inc_sum  = {1'b0, act_seg} + Inc;
        inc_min6 = {1'b0, act_min};
        inc_seg  = inc_sum[5:0];
        if (inc_sum >= 7'd60) begin
            inc_seg  = 6'(inc_sum - 7'd60);
            inc_min6 = {1'b0, act_min} + 6'd1;
        end
        inc_min = inc_min6[4:0];
        // Saturate at 31:59 when the carry overflows the minute field.
        if (inc_min6 > 6'd31) begin
            inc_min = 5'd31;
            inc_seg = 6'd59;
        end
    end

    // Game FSM, prescaler and registered player times/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= StIdle;
            cnt_q <= '0;
            min1  <= MinInit;
            seg1  <= SegInit;
            min2  <= MinInit;
            seg2  <= SegInit;
            turn  <= 1'b0;
            flag1 <= 1'b0;
            flag2 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (start && (st_q == StPaused || st_q == StFlag)) begin
                st_q  <= StIdle;
                cnt_q <= '0;
                min1  <= MinInit;
                seg1  <= SegInit;
                min2  <= MinInit;
                seg2  <= SegInit;
                turn  <= 1'b0;
                flag1 <= 1'b0;
                flag2 <= 1'b0;
            end else begin
                unique case (st_q)
                    StIdle: begin
                        if (start) begin
                            st_q  <= StRun1;
                            cnt_q <= '0;
                        end
                    end
                    StRun1, StRun2: begin
                        // start is ignored while running; lower priorities still apply.
                        if (pause) begin
                            st_q <= StPaused;
                        end else if (act_btn) begin
                            if (turn) begin
                                min2 <= inc_min;
                                seg2 <= inc_seg;
                            end else begin
                                min1 <= inc_min;
                                seg1 <= inc_seg;
                            end
                            st_q  <= turn ? StRun1 : StRun2;
                            turn  <= ~turn;
                            cnt_q <= '0;
                        end else if (at_tc) begin
                            cnt_q <= '0;
                            tick  <= act_nonzero;
                            if (turn) begin
                                min2 <= dec_min;
                                seg2 <= dec_seg;
                            end else begin
                                min1 <= dec_min;
                                seg1 <= dec_seg;
                            end
                            if (dec_zero) begin
                                st_q <= StFlag;
                                if (turn) flag2 <= 1'b1;
                                else      flag1 <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StPaused: begin
                        if (pause) st_q <= turn ? StRun2 : StRun1;
                    end
                    StFlag: begin
                        st_q <= StFlag;
                    end
                    default: st_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chess_clock_core.sv
// Bench for chess_clock_core: six instances with different start/increment
// settings share one stimulus; each scenario checks the instance it targets.
module tb_chess_clock_core;

    localparam int Hz   = 4;
    localparam int NDut = 6;
    // Instance 2 settings, used by the vector table and the reference model.
    localparam int CStart = 10;
    localparam int CInc   = 5;
    localparam int Cap    = 31 * 60 + 59;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic btn1 = 1'b0;
    logic btn2 = 1'b0;

    logic [4:0] min1_w [NDut];
    logic [4:0] min2_w [NDut];
    logic [5:0] seg1_w [NDut];
    logic [5:0] seg2_w [NDut];
    logic [2:0] state_w[NDut];
    logic       turn_w [NDut];
    logic       flag1_w[NDut];
    logic       flag2_w[NDut];
    logic       tick_w [NDut];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: 0:03 inc 0, 1: 1:00 inc 0, 2: 0:10 inc 5, 3: 31:58 inc 5, 4: 0:58 inc 5, 5: 0:01 inc 5
    for (genvar g = 0; g < NDut; g++) begin : g_dut
        localparam int unsigned SMin = (g == 1) ? 1 : (g == 3) ? 31 : 0;
        localparam int unsigned SSeg = (g == 0) ? 3 : (g == 1) ? 0 : (g == 2) ? 10 :
                                       (g == 5) ? 1 : 58;
        localparam int unsigned SInc = (g <= 1) ? 0 : 5;
        chess_clock_core #(
            .CLK_HZ   (Hz),
            .START_MIN(SMin),
            .START_SEG(SSeg),
            .INC_SEG  (SInc)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start),
            .pause(pause),
            .btn1 (btn1),
            .btn2 (btn2),
            .min1 (min1_w[g]),
            .min2 (min2_w[g]),
            .seg1 (seg1_w[g]),
            .seg2 (seg2_w[g]),
            .turn (turn_w[g]),
            .state(state_w[g]),
            .flag1(flag1_w[g]),
            .flag2(flag2_w[g]),
            .tick (tick_w[g])
        );
    end

    typedef struct {
        logic s, p, b1, b2;
        int   m1, s1, m2, s2, tr, st, f1, f2, tk;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic s, p, b1, b2,
                                input int m1, s1, m2, s2, tr, st, f1, f2, tk);
        vec_t v;
        v.s = s; v.p = p; v.b1 = b1; v.b2 = b2;
        v.m1 = m1; v.s1 = s1; v.m2 = m2; v.s2 = s2;
        v.tr = tr; v.st = st; v.f1 = f1; v.f2 = f2; v.tk = tk;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    // Compare every output of instance 2 against an expected set.
    task automatic chk_c(input string tag, input int m1, s1, m2, s2, tr, st, f1, f2, tk);
        chk({tag, " min1"}, int'(min1_w[2]), m1);
        chk({tag, " seg1"}, int'(seg1_w[2]), s1);
        chk({tag, " min2"}, int'(min2_w[2]), m2);
        chk({tag, " seg2"}, int'(seg2_w[2]), s2);
        chk({tag, " turn"}, int'(turn_w[2]), tr);
        chk({tag, " state"}, int'(state_w[2]), st);
        chk({tag, " flag1"}, int'(flag1_w[2]), f1);
        chk({tag, " flag2"}, int'(flag2_w[2]), f2);
        chk({tag, " tick"}, int'(tick_w[2]), tk);
    endtask

    // One clock cycle with the given input pulses; returns 1 time unit after the edge.
    task automatic cyc(input logic s, p, b1, b2);
        start = s; pause = p; btn1 = b1; btn2 = b2;
        @(posedge clk);
        #1;
        start = 1'b0; pause = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model for instance 2: each time as total seconds, game phase as a small int.
    int m_t[2];
    int m_f[2];
    int m_mode;  // 0 idle, 1 running, 2 paused, 3 timed out
    int m_who;
    int m_pc;
    int m_tk;

    task automatic m_reload();
        m_t[0] = CStart; m_t[1] = CStart;
        m_f[0] = 0; m_f[1] = 0;
        m_mode = 0; m_who = 0; m_pc = 0; m_tk = 0;
    endtask

    task automatic m_step(input logic s, p, b1, b2);
        m_tk = 0;
        if (m_mode == 0) begin
            if (s) begin
                m_mode = 1;
                m_pc = 0;
            end
        end else if (m_mode == 1) begin
            if (p) begin
                m_mode = 2;
            end else if ((m_who == 0 && b1) || (m_who == 1 && b2)) begin
                m_t[m_who] = (m_t[m_who] + CInc > Cap) ? Cap : m_t[m_who] + CInc;
                m_who = 1 - m_who;
                m_pc = 0;
            end else if (m_pc == Hz - 1) begin
                m_pc = 0;
                if (m_t[m_who] > 0) begin
                    m_t[m_who] = m_t[m_who] - 1;
                    m_tk = 1;
                end
                if (m_t[m_who] == 0) begin
                    m_f[m_who] = 1;
                    m_mode = 3;
                end
            end else begin
                m_pc++;
            end
        end else if (m_mode == 2) begin
            if (s) m_reload();
            else if (p) m_mode = 1;
        end else begin
            if (s) m_reload();
        end
    endtask

    function automatic int m_state();
        case (m_mode)
            0:       return 0;
            1:       return (m_who == 1) ? 2 : 1;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    initial begin
        // Vectors for instance 2 (0:10, +5 s, 4 cycles per second), starting from reset.
        vecs[0]  = mk(1, 0, 0, 0, 0, 10, 0, 10, 0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 10, 0, 10, 0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0, 15, 0, 10, 1, 2, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 15, 0, 10, 1, 2, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 15, 0, 15, 0, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 15, 0, 15, 0, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 15, 0, 15, 0, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 15, 0, 15, 0, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 14, 0, 15, 0, 1, 0, 0, 1);
        vecs[9]  = mk(0, 1, 0, 0, 0, 14, 0, 15, 0, 3, 0, 0, 0);
        vecs[10] = mk(0, 0, 1, 0, 0, 14, 0, 15, 0, 3, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 14, 0, 15, 0, 1, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 1, 0, 14, 0, 15, 0, 1, 0, 0, 0);
        vecs[13] = mk(0, 1, 0, 0, 0, 14, 0, 15, 0, 3, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 0, 0, 10, 0, 10, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        do_reset();
        chk_c("reset", 0, 10, 0, 10, 0, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].s, vecs[i].p, vecs[i].b1, vecs[i].b2);
            chk_c($sformatf("vec%0d", i), vecs[i].m1, vecs[i].s1, vecs[i].m2, vecs[i].s2,
                  vecs[i].tr, vecs[i].st, vecs[i].f1, vecs[i].f2, vecs[i].tk);
        end

        // Countdown to timeout on instance 0 (0:03).
        do_reset();
        cyc(1, 0, 0, 0);
        chk("cd run state", int'(state_w[0]), 1);
        chk("cd seg1 start", int'(seg1_w[0]), 3);
        idle(3);
        chk("cd seg1 before tc", int'(seg1_w[0]), 3);
        idle(1);
        chk("cd seg1 first tick", int'(seg1_w[0]), 2);
        chk("cd tick pulse", int'(tick_w[0]), 1);
        idle(4);
        chk("cd seg1 second", int'(seg1_w[0]), 1);
        idle(4);
        chk("cd seg1 zero", int'(seg1_w[0]), 0);
        chk("cd flag1", int'(flag1_w[0]), 1);
        chk("cd flag state", int'(state_w[0]), 4);
        chk("cd seg2 held", int'(seg2_w[0]), 3);
        chk("cd flag2", int'(flag2_w[0]), 0);
        idle(4);
        chk("cd frozen state", int'(state_w[0]), 4);
        chk("cd frozen seg1", int'(seg1_w[0]), 0);
        cyc(1, 0, 0, 0);
        chk("flag start state", int'(state_w[0]), 0);
        chk("flag start seg1", int'(seg1_w[0]), 3);
        chk("flag start flag1", int'(flag1_w[0]), 0);

        // Asynchronous reset mid-run.
        cyc(1, 0, 0, 0);
        idle(5);
        chk("pre rst seg1", int'(seg1_w[0]), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst seg1", int'(seg1_w[0]), 3);
        chk("async rst state", int'(state_w[0]), 0);
        #1;
        rst_n = 1'b1;

        // Minute borrow on instance 1 (1:00).
        do_reset();
        cyc(1, 0, 0, 0);
        idle(3);
        chk("borrow min1 pre", int'(min1_w[1]), 1);
        chk("borrow tick pre", int'(tick_w[1]), 0);
        idle(1);
        chk("borrow min1", int'(min1_w[1]), 0);
        chk("borrow seg1", int'(seg1_w[1]), 59);
        chk("borrow tick", int'(tick_w[1]), 1);
        idle(1);
        chk("borrow tick end", int'(tick_w[1]), 0);

        // Saturation on instance 3 (31:58) and carry on instance 4 (0:58).
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("sat min1", int'(min1_w[3]), 31);
        chk("sat seg1", int'(seg1_w[3]), 59);
        chk("sat state", int'(state_w[3]), 2);
        chk("carry min1", int'(min1_w[4]), 1);
        chk("carry seg1", int'(seg1_w[4]), 3);

        // Button coincident with terminal count on instance 5 (0:01): tick discarded.
        do_reset();
        cyc(1, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 0);
        chk("coin flag1", int'(flag1_w[5]), 0);
        chk("coin seg1", int'(seg1_w[5]), 6);
        chk("coin state", int'(state_w[5]), 2);
        chk("coin turn", int'(turn_w[5]), 1);
        do_reset();
        cyc(1, 0, 0, 0);
        idle(4);
        chk("nocoin flag1", int'(flag1_w[5]), 1);
        chk("nocoin state", int'(state_w[5]), 4);

        // Pause in RUN2 at prescaler count 2 on instance 2.
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(2);
        cyc(0, 1, 0, 0);
        chk("pause state", int'(state_w[2]), 3);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("paused seg2 c%0d", i), int'(seg2_w[2]), 10);
        end
        chk("paused seg1", int'(seg1_w[2]), 15);
        chk("paused state hold", int'(state_w[2]), 3);
        cyc(0, 1, 0, 0);
        chk("resume state", int'(state_w[2]), 2);
        chk("resume turn", int'(turn_w[2]), 1);
        idle(1);
        chk("resume seg2 pre", int'(seg2_w[2]), 10);
        idle(1);
        chk("resume seg2 tick", int'(seg2_w[2]), 9);
        chk("resume tick", int'(tick_w[2]), 1);

        // Random pulses on instance 2 against the reference model.
        do_reset();
        m_reload();
        for (int i = 0; i < 3000; i++) begin
            logic s, p, b1, b2;
            s  = ($urandom_range(0, 99) < 2);
            p  = ($urandom_range(0, 99) < 3);
            b1 = ($urandom_range(0, 99) < 3);
            b2 = ($urandom_range(0, 99) < 3);
            m_step(s, p, b1, b2);
            cyc(s, p, b1, b2);
            chk_c($sformatf("rnd%0d", i), m_t[0] / 60, m_t[0] % 60, m_t[1] / 60, m_t[1] % 60,
                  m_who, m_state(), m_f[0], m_f[1], m_tk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
